// File: rtl/bus10_pkg.sv
// Shared definitions for the bus10 arbiter slice: FSM state encoding,
// the transfer-counter wrap limit and the default burst length.
package bus10_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  // Highest value the accepted-beat counter reaches before wrapping to 0
  localparam logic [9:0] MOD_LIMIT = 10'd999;

  // Beats per tenure when the instantiating design does not override it
  localparam int DEFAULT_MAX_BURST = 4;

endpackage : bus10_pkg

// File: rtl/bus10_arbiter_mod1000_counter.sv
// Modulo-1000 event counter: counts enabled cycles 0..999 and wraps to 0.
// Used by bus10_arbiter to report accepted beats when BUS10_XFER_CNT_EN is set.
module mod1000_counter
  import bus10_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clear,
  output logic [9:0] o_count
);

  logic [9:0] r_count;

  // Count enabled cycles; clear and reset both take priority over counting
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == MOD_LIMIT) ? 10'd0 : r_count + 10'd1;
    end
  end

  assign o_count = r_count;

endmodule : mod1000_counter

// File: rtl/bus10_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared 10-bit mux10
// datapath. Owns the mux select and the per-requester grant/ready, forwards
// downstream backpressure and caps each tenure at MAX_BURST beats.
// Optional feature macro: BUS10_XFER_CNT_EN adds the xfer_cnt output, a
// modulo-1000 count of accepted beats.
module bus10_arbiter
  import bus10_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int CNT_W     = 4
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       out_ready,
  output logic       sel,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rdy0,
  output logic       rdy1,
  output logic       out_valid,
  output logic       busy
`ifdef BUS10_XFER_CNT_EN
  ,
  output logic [9:0] xfer_cnt
`endif
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  state_t           r_state;
  logic             r_sel;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_busy;
  logic             r_last_gnt;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_gnt;
  logic [1:0]       w_req;
  logic [1:0]       w_rdy;
  logic [1:0]       w_take;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_beat;
  logic             w_burst_done;

  assign w_gnt = {r_gnt1, r_gnt0};
  assign w_req = {req1, req0};

  // Per-requester handshake. Ready is masked while reset is asserted so a
  // tenure aborted by reset never accepts a beat in that cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_rdy[gi]  = w_gnt[gi] & out_ready & rst_n;
      assign w_take[gi] = w_rdy[gi] & w_req[gi];
    end
  endgenerate

  assign w_beat       = |w_take;
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_burst_done = w_beat && (w_cnt_inc == BURST_LAST);

  // Arbitration FSM; grant, select and busy are registered copies of the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_sel      <= 1'b0;
      r_busy     <= 1'b0;
      r_last_gnt <= 1'b1;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Tie goes to whichever requester was not served last
          if (req0 && (!req1 || r_last_gnt)) begin
            r_state <= G0;
            r_gnt0  <= 1'b1;
            r_sel   <= 1'b0;
            r_busy  <= 1'b1;
          end else if (req1) begin
            r_state <= G1;
            r_gnt1  <= 1'b1;
            r_sel   <= 1'b1;
            r_busy  <= 1'b1;
          end
          r_cnt <= '0;
        end

        G0: begin
          if (!req0 || w_burst_done) begin
            r_last_gnt <= 1'b0;
            r_cnt      <= '0;
            if (req1) begin
              r_state <= G1;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b1;
              r_sel   <= 1'b1;
            end else if (req0) begin
              // Burst limit hit with nobody else waiting: fresh tenure for 0
              r_state <= G0;
            end else begin
              r_state <= IDLE;
              r_gnt0  <= 1'b0;
              r_busy  <= 1'b0;
            end
          end else if (w_take[0]) begin
            r_cnt <= w_cnt_inc;
          end
        end

        G1: begin
          if (!req1 || w_burst_done) begin
            r_last_gnt <= 1'b1;
            r_cnt      <= '0;
            if (req0) begin
              r_state <= G0;
              r_gnt1  <= 1'b0;
              r_gnt0  <= 1'b1;
              r_sel   <= 1'b0;
            end else if (req1) begin
              r_state <= G1;
            end else begin
              r_state <= IDLE;
              r_gnt1  <= 1'b0;
              r_busy  <= 1'b0;
            end
          end else if (w_take[1]) begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign busy      = r_busy;
  assign rdy0      = w_rdy[0];
  assign rdy1      = w_rdy[1];
  assign out_valid = rst_n & ((r_gnt0 & req0) | (r_gnt1 & req1));

`ifdef BUS10_XFER_CNT_EN
  logic [9:0] w_xfer_cnt;

  mod1000_counter u_xfer_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_beat),
    .i_clear (1'b0),
    .o_count (w_xfer_cnt)
  );

  assign xfer_cnt = w_xfer_cnt;
`endif

endmodule : bus10_arbiter

// File: tb/tb_bus10_arbiter.sv
// Directed testbench for bus10_arbiter (MAX_BURST = 4). Expected values are
// hand-derived from the arbiter's intended behaviour. Define
// BUS10_XFER_CNT_EN to also exercise the accepted-beat counter.
module tb_bus10_arbiter;

  logic clk;
  logic rst_n;
  logic req0;
  logic req1;
  logic out_ready;
  logic sel;
  logic gnt0;
  logic gnt1;
  logic rdy0;
  logic rdy1;
  logic out_valid;
  logic busy;
`ifdef BUS10_XFER_CNT_EN
  logic [9:0] xfer_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  bus10_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rdy0      (rdy0),
    .rdy1      (rdy1),
    .out_valid (out_valid),
    .busy      (busy)
`ifdef BUS10_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per comparison; mismatches carry the FAIL keyword
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance past the next rising edge and let registered outputs settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow newly driven inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req0      = 1'b1;
    req1      = 1'b1;
    out_ready = 1'b1;

    // Reset held two cycles with both requesters active
    step();
    step();
    chk("rst_sel", sel, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", rdy0, 0);

    // First tie after reset goes to requester 0
    rst_n = 1'b1;
    step();
    chk("tie_gnt0", gnt0, 1);
    chk("tie_busy", busy, 1);

    // Contention: 4 beats G0, 4 beats G1, 4 beats G0, no dead cycles
    for (int k = 0; k < 12; k++) begin
      automatic logic [31:0] own = ((k / 4) % 2 == 1) ? 32'd1 : 32'd0;
      chk($sformatf("cont%0d_sel", k), sel, own);
      chk($sformatf("cont%0d_gnt0", k), gnt0, (own == 0) ? 1 : 0);
      chk($sformatf("cont%0d_gnt1", k), gnt1, own);
      chk($sformatf("cont%0d_valid", k), out_valid, 1);
      step();
    end
    // Third tenure ended on its 4th beat, so requester 1 owns it again
    chk("cont_end_gnt1", gnt1, 1);

    // Both requests drop: release to IDLE, select holds its last value
    req0 = 1'b0;
    req1 = 1'b0;
    settle();
    chk("drop_valid", out_valid, 0);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_gnt1", gnt1, 0);
    chk("idle_sel_hold", sel, 1);

    // Lone requester 1: grant after one cycle, 3 beats, then release
    req1 = 1'b1;
    settle();
    chk("lone_pregrant", gnt1, 0);
    step();
    chk("lone_gnt1", gnt1, 1);
    chk("lone_sel", sel, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lone_rdy1_%0d", k), rdy1, 1);
      step();
    end
    req1 = 1'b0;
    settle();
    chk("lone_valid_low", out_valid, 0);
    step();
    chk("lone_idle_busy", busy, 0);
    chk("lone_idle_gnt1", gnt1, 0);

    // Backpressure: two beats in G0, stall 5 cycles, then finish the burst
    req0 = 1'b1;
    step();
    chk("bp_gnt0", gnt0, 1);
    chk("bp_sel", sel, 0);
    step();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("bp_stall%0d_rdy0", k), rdy0, 0);
      chk($sformatf("bp_stall%0d_gnt0", k), gnt0, 1);
      step();
    end
    out_ready = 1'b1;
    req1      = 1'b1;
    settle();
    chk("bp_resume_a_rdy0", rdy0, 1);
    step();
    chk("bp_resume_b_gnt0", gnt0, 1);
    step();
    // Burst count frozen during the stall: ends exactly after beat 4
    chk("bp_done_gnt1", gnt1, 1);
    chk("bp_done_sel", sel, 1);

    // Early release: G1 drops req after 2 beats while req0 waits
    step();
    step();
    req1 = 1'b0;
    settle();
    chk("early_valid", out_valid, 0);
    step();
    chk("early_gnt0", gnt0, 1);
    chk("early_gnt1", gnt1, 0);
    chk("early_sel", sel, 0);

    // G0 releases to IDLE; next tie must go to requester 1
    req0 = 1'b0;
    step();
    chk("rr_idle", busy, 0);
    req0 = 1'b1;
    req1 = 1'b1;
    step();
    chk("rr_gnt1", gnt1, 1);
    chk("rr_gnt0", gnt0, 0);

    // Burst limit with nobody else waiting re-grants the same requester
    req0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("regrant_rdy1_%0d", k), rdy1, 1);
      step();
    end
    chk("regrant_gnt1", gnt1, 1);
    chk("regrant_busy", busy, 1);

    // Reset mid-tenure: nothing accepted in the reset cycle
    step();
    rst_n = 1'b0;
    settle();
    chk("midrst_rdy1", rdy1, 0);
    chk("midrst_valid", out_valid, 0);
    step();
    chk("midrst_gnt1", gnt1, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sel", sel, 0);
    rst_n = 1'b1;
    req1  = 1'b0;
    step();

`ifdef BUS10_XFER_CNT_EN
    // 1002 back-to-back beats from requester 0 wrap the counter to 2
    chk("xfer_start", xfer_cnt, 0);
    req0 = 1'b1;
    step();
    for (int i = 1; i <= 1002; i++) begin
      step();
      if (i == 999)  chk("xfer_999", xfer_cnt, 999);
      if (i == 1000) chk("xfer_wrap", xfer_cnt, 0);
    end
    chk("xfer_1002", xfer_cnt, 2);
    rst_n = 1'b0;
    step();
    chk("xfer_rst", xfer_cnt, 0);
    rst_n = 1'b1;
    req0  = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bus10_arbiter

// File: doc/bus10_arbiter.md
Name: bus10_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 10-bit mux10 datapath (i0 = requester 0, i1 = requester 1).
- Drives the mux select `sel` and the per-requester grant/ready.
- Forwards downstream backpressure and bounds each tenure to MAX_BURST beats.
- Does not touch data; data flows through the external mux10.

Parameters:
- MAX_BURST, 4, maximum beats per grant tenure before forced re-arbitration; legal 1..15.
- CNT_W, 4, beat-counter width; must hold MAX_BURST.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req0  input  1  requester 0 has a valid beat on mux10 i0
- req1  input  1  requester 1 has a valid beat on mux10 i1
- out_ready  input  1  downstream accepts beat this cycle
- sel  output  1  mux10 select; 0 = i0, 1 = i1; registered
- gnt0  output  1  requester 0 owns the datapath; registered
- gnt1  output  1  requester 1 owns the datapath; registered
- rdy0  output  1  requester 0 beat accepted this cycle (gnt0 & out_ready); combinational
- rdy1  output  1  requester 1 beat accepted this cycle (gnt1 & out_ready); combinational
- out_valid  output  1  beat valid on mux10 y (gnt0&req0 | gnt1&req1); combinational
- busy  output  1  state != IDLE; registered
- xfer_cnt  output  10  mod-1000 accepted-beat count; present only with BUS10_XFER_CNT_EN

Behaviour:
- Reset (rst_n low at edge):
  - state = IDLE; gnt0 = gnt1 = 0; sel = 0; busy = 0; beat count = 0.
  - last_gnt = 1, so requester 0 wins the first tie.
  - xfer_cnt = 0.
  - Reset mid-tenure aborts immediately; no beat is accepted in the reset cycle.
- States: IDLE, G0, G1. gnt0 = (state==G0), gnt1 = (state==G1).
- sel changes only on entry to G0 (sel = 0) or G1 (sel = 1). In IDLE it holds its last value.
- Arbitration latency: a req seen in IDLE produces the grant on the next edge (1 cycle).
- IDLE transitions:
  - only req0 -> G0
  - only req1 -> G1
  - both -> the requester != last_gnt
  - none -> stay IDLE
- Beat: a transfer occurs on a cycle with gnt_i & req_i & out_ready. The beat counter increments on each beat.
- Tenure ends at the edge where either:
  - a beat makes count == MAX_BURST, or
  - req_i is low while gnt_i is high.
- At tenure end, record last_gnt = i, clear count, then:
  - other req high -> grant other directly (no idle bubble)
  - else own req still high (burst-limit case) -> re-grant self with fresh count
  - else -> IDLE
- out_ready low stalls: count and grant hold and nothing is accepted. There is no timeout.
- Requester contract: req_i and data stay stable until rdy_i. A grantee dropping req releases at the next edge.
- Both reqs held continuously with out_ready = 1 give alternating MAX_BURST-beat tenures with no dead cycles.
- Never gnt0 & gnt1.

Optional Feature:
- Macro BUS10_XFER_CNT_EN.
- Defined:
  - xfer_cnt port exists; 10-bit register incremented on every accepted beat from either requester.
  - Wraps 999 -> 0, so it never reaches 1000.
  - Reset to 0.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package bus10_pkg holds:
  - state enum (IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2)
  - MOD_LIMIT = 10'd999
  - DEFAULT_MAX_BURST = 4
- One natural sub-module: mod1000_counter (en, clear, 10-bit count, wrap at 999), instantiated only under BUS10_XFER_CNT_EN.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with req0 = req1 = 1 -> sel = 0, gnt0 = gnt1 = 0, busy = 0. After release, gnt0 = 1 on the first edge (tie goes to 0).
- Lone requester: req1 = 1 for 3 beats, then drops, out_ready = 1 -> gnt1 one cycle after req, sel = 1, 3 rdy1 pulses, IDLE the cycle after req1 falls.
- Contention: both reqs held, MAX_BURST = 4, out_ready = 1 -> 4 beats G0, 4 beats G1, 4 beats G0; sel toggles with no gap cycles.
- Backpressure: in G0 hold out_ready = 0 for 5 cycles mid-burst -> count frozen, no rdy0, gnt0 held; burst completes after out_ready returns.
- Early release: grantee drops req after 2 beats while the other is requesting -> grant switches next edge and last_gnt updates.
- With BUS10_XFER_CNT_EN, 1002 accepted beats -> xfer_cnt reads 2 (passes 999 -> 0). Reset mid-stream -> 0.
